// File: rtl/alaw_decode_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : alaw_decode_scheduler (with helper alaw_expand)
//  Brief    : Round-robin arbiter sharing one A-law expander between NUM_CH
//             channels; registers the signed 13-bit linear sample plus the
//             source channel tag behind a one-deep output register.
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  alaw_expand : combinational 8-bit A-law code to 13-bit two's-complement
//  linear sample. Segment 0 is linear; each higher segment carries an implied
//  leading one and doubles the step size.
// ----------------------------------------------------------------------------
module alaw_expand (
    input  logic [7:0]  i_code,
    output logic [12:0] o_lin
);
    logic [2:0]  w_seg;
    logic [3:0]  w_mant;
    logic [11:0] w_base;
    logic [11:0] w_mag;
    logic [12:0] w_pos;

    assign w_seg  = i_code[6:4];
    assign w_mant = i_code[3:0];
    // Segment-1 shape: implied leading one, mantissa, half-step rounding bit.
    assign w_base = {6'b0, 1'b1, w_mant, 1'b1};

    // Magnitude: segment 0 has no implied one; segment s is segment 1 << (s-1).
    always_comb begin
        w_mag = {7'b0, w_mant, 1'b1};
        if (w_seg != 3'd0) begin
            w_mag = w_base << (w_seg - 3'd1);
        end
    end

    assign w_pos = {1'b0, w_mag};
    // Bit 7 set means positive; otherwise negate (magnitude is never zero).
    assign o_lin = i_code[7] ? w_pos : (13'd0 - w_pos);
endmodule

// ----------------------------------------------------------------------------
//  alaw_decode_scheduler : top level
// ----------------------------------------------------------------------------
module alaw_decode_scheduler #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [NUM_CH-1:0]     req_valid,
    input  logic [8*NUM_CH-1:0]   req_data,
    output logic [NUM_CH-1:0]     req_ready,
    output logic                  out_valid,
    output logic [12:0]           out_data,
    output logic [CH_W-1:0]       out_ch,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      sample_cnt
);
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [CH_W-1:0] c_last_ch = CH_W'(NUM_CH - 1);

    state_t            r_state;
    logic [12:0]       r_out_data;
    logic [CH_W-1:0]   r_out_ch;
    logic [CH_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]  r_sample_cnt;

    logic              w_can_accept;
    logic              w_found;
    logic [CH_W-1:0]   w_winner;
    logic [CH_W-1:0]   w_next_ptr;
    logic [7:0]        w_code;
    logic [12:0]       w_lin;
    logic              w_transfer;

    // Accept when enabled and the output register is empty or draining now;
    // gated by rst_n so no grant is shown while reset is held.
    assign w_can_accept = rst_n & en & ((r_state == ST_EMPTY) | out_ready);

    // Round-robin search starting at r_rr_ptr; first requesting channel wins
    // and its code is steered to the shared expander.
    always_comb begin : p_arb
        int idx;
        w_found  = 1'b0;
        w_winner = '0;
        w_code   = '0;
        idx      = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (!w_found && req_valid[c] && (c == idx)) begin
                    w_found  = 1'b1;
                    w_winner = CH_W'(c);
                    w_code   = req_data[8*c +: 8];
                end
            end
        end
    end

    assign w_transfer = w_can_accept & w_found;
    assign w_next_ptr = (w_winner == c_last_ch) ? '0 : (w_winner + CH_W'(1));

    // One-hot grant to the winner only; never a function of req_data.
    assign req_ready = w_transfer ? ({{(NUM_CH-1){1'b0}}, 1'b1} << w_winner)
                                  : '0;

    alaw_expand u_expand (
        .i_code (w_code),
        .o_lin  (w_lin)
    );

    // Output register: load on transfer, empty on drain, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_out_data   <= '0;
            r_out_ch     <= '0;
            r_rr_ptr     <= '0;
            r_sample_cnt <= '0;
        end else if (w_transfer) begin
            r_state      <= ST_FULL;
            r_out_data   <= w_lin;
            r_out_ch     <= w_winner;
            r_rr_ptr     <= w_next_ptr;
            r_sample_cnt <= r_sample_cnt + CNT_W'(1);
        end else if ((r_state == ST_FULL) && out_ready) begin
            r_state      <= ST_EMPTY;
        end
    end

    assign out_valid  = (r_state == ST_FULL);
    assign out_data   = r_out_data;
    assign out_ch     = r_out_ch;
    assign sample_cnt = r_sample_cnt;
endmodule
`default_nettype wire

// File: tb/tb_alaw_decode_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alaw_decode_scheduler
//  Brief    : Directed and randomized bench with a behavioural reference model
//             of the round-robin A-law scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alaw_decode_scheduler;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                en = 1'b0;
    logic                out_ready = 1'b0;
    logic [NUM_CH-1:0]   req_valid = '0;
    logic [8*NUM_CH-1:0] req_data = '0;
    logic [NUM_CH-1:0]   req_ready;
    logic                out_valid;
    logic [12:0]         out_data;
    logic [CH_W-1:0]     out_ch;
    logic [CNT_W-1:0]    sample_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_valid;
    logic [12:0] m_data;
    int          m_ch;
    int          m_ptr;
    int          m_cnt;

    alaw_decode_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_ready  (out_ready),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    // Standard A-law expansion computed arithmetically.
    function automatic logic [12:0] ref_lin(input logic [7:0] code);
        int seg;
        int m;
        int mag;
        seg = int'(code[6:4]);
        m   = int'(code[3:0]);
        if (seg == 0) mag = 2*m + 1;
        else          mag = (2*m + 33) * (1 << (seg - 1));
        return code[7] ? 13'(mag) : 13'(-mag);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = 0;
        m_ptr   = 0;
        m_cnt   = 0;
    endtask

    // One clock: check grant against the model, advance model, check outputs.
    task automatic step(input bit chk);
        int win;
        int c;
        bit can;
        logic [NUM_CH-1:0] exp_rdy;
        #1;
        can = en && (!m_valid || out_ready);
        win = -1;
        for (int k = 0; k < NUM_CH; k++) begin
            c = (m_ptr + k) % NUM_CH;
            if (win < 0 && req_valid[c]) win = c;
        end
        exp_rdy = (can && win >= 0) ? (NUM_CH'(1) << win) : '0;
        if (chk) check("req_ready", 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        if (can && win >= 0) begin
            m_valid = 1'b1;
            m_ch    = win;
            m_data  = ref_lin(req_data[8*win +: 8]);
            m_ptr   = (win + 1) % NUM_CH;
            m_cnt   = (m_cnt + 1) % (1 << CNT_W);
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        if (chk) begin
            check("out_valid",  32'(out_valid),  32'(m_valid));
            check("out_data",   32'(out_data),   32'(m_data));
            check("out_ch",     32'(out_ch),     32'(m_ch));
            check("sample_cnt", 32'(sample_cnt), 32'(m_cnt));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_code(input int ch, input logic [7:0] code);
        req_data[8*ch +: 8] = code;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        // Reset state
        check("rst_out_valid",  32'(out_valid),  32'h0);
        check("rst_out_data",   32'(out_data),   32'h0);
        check("rst_out_ch",     32'(out_ch),     32'h0);
        check("rst_sample_cnt", 32'(sample_cnt), 32'h0);
        check("rst_req_ready",  32'(req_ready),  32'h0);
        rst_n = 1'b1;

        // Smallest codes on channel 0
        en = 1'b1; out_ready = 1'b1; req_valid = 4'b0001;
        set_code(0, 8'h80); step(1);
        check("t1_pos_min", 32'(out_data), 32'h0001);
        set_code(0, 8'h00); step(1);
        check("t1_neg_min", 32'(out_data), 32'h1FFF);

        // Extremes and a mid-segment code
        set_code(0, 8'hFF); step(1);
        check("t2_pos_max", 32'(out_data), 32'h0FC0);
        set_code(0, 8'h7F); step(1);
        check("t2_neg_max", 32'(out_data), 32'h1040);
        set_code(0, 8'hA5); step(1);
        check("t2_a5", 32'(out_data), 32'h0056);

        // All channels streaming: rotating grants, one sample per cycle
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < NUM_CH; i++) set_code(i, 8'(8'h90 + i));
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("t3_rr_ch", 32'(out_ch), 32'(i % NUM_CH));
            check("t3_cnt", 32'(sample_cnt), 32'(i + 1));
        end

        // Backpressure: held sample stays put, no grants
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("t4_hold_ch", 32'(out_ch), 32'h3);
        end
        out_ready = 1'b1;
        step(1);
        check("t4_reload_valid", 32'(out_valid), 32'h1);
        check("t4_reload_ch", 32'(out_ch), 32'h0);

        // Enable low: drain only, pointer kept
        do_reset();
        req_valid = 4'b0011;
        step(1); step(1);
        req_valid = 4'b1100; en = 1'b0;
        for (int i = 0; i < 3; i++) step(1);
        check("t5_drained", 32'(out_valid), 32'h0);
        en = 1'b1;
        step(1);
        check("t5_resume_ch", 32'(out_ch), 32'h2);

        // Asynchronous reset mid-stream
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 37; i++) step(1);
        check("t6_cnt37", 32'(sample_cnt), 32'd37);
        #2 rst_n = 1'b0;
        #1;
        check("t6_arst_valid", 32'(out_valid),  32'h0);
        check("t6_arst_cnt",   32'(sample_cnt), 32'h0);
        check("t6_arst_ready", 32'(req_ready),  32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        check("t6_ptr_zero", 32'(out_ch), 32'h0);

        // Counter wrap
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 65535; i++) step(0);
        check("t6_cnt_ffff", 32'(sample_cnt), 32'hFFFF);
        step(1);
        check("t6_cnt_wrap", 32'(sample_cnt), 32'h0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req_valid = NUM_CH'($urandom);
            req_data  = (8*NUM_CH)'($urandom);
            en        = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            step(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
